memory_stage: RTL and testbench
===============================

# memory_stage

Memory (MEM) stage of the five-stage RISC-V pipeline. It consumes the EX/MEM pipeline bundle produced by the execute stage and performs data-memory stores and loads against an internal word-addressed data memory. It registers the MEM/WB bundle for the writeback stage and flags misaligned or out-of-range accesses.

## Interface
Parameters:
- DEPTH, 64, number of 32-bit words in data memory (any value ≥ 2).
- AW, $clog2(DEPTH), word-index width (derived; do not override).

Ports:
- clk  input  1  pipeline clock, rising edge active.
- rst  input  1  asynchronous, active-low reset.
- regwriteM  input  1  register-file write enable for this instruction.
- memwriteM  input  1  store enable.
- resultsrcM  input  1  0 = writeback selects ALU result, 1 = writeback selects load data.
- resultM  input  32  ALU result; byte address for loads/stores.
- writedataM  input  32  store data (rs2 value).
- RdM  input  5  destination register.
- pc4M  input  32  PC+4 of the instruction.
- regwriteW  output  1  registered regwriteM.
- resultsrcW  output  1  registered resultsrcM.
- RdW  output  5  registered RdM.
- pc4W  output  32  registered pc4M.
- aluresultW  output  32  registered resultM.
- readdataW  output  32  registered load data.
- faultW  output  1  registered access fault of this instruction.
- fault_sticky  output  1  set by any fault, cleared only by reset.

## Operation
- Word index = resultM[AW+1:2]. Access is "in range" when resultM[31:2] < DEPTH.
- Access is "aligned" when resultM[1:0] == 2'b00.
- Fault = (memwriteM | resultsrcM) & (!aligned | !in range). ALU-only instructions (memwriteM = 0, resultsrcM = 0) never fault, whatever their address.
- Store: when memwriteM = 1 and there is no fault, mem[index] <= writedataM at the rising edge. A faulting store is dropped; memory is unchanged.
- Load data: mem[index] read combinationally. It is forced to 32'h0 when the access is not in range or not aligned.
- MEM/WB register: on every rising edge out of reset, all W outputs capture the corresponding M inputs. This covers readdataW and faultW.
- regwriteW passes through unchanged even on fault. Suppressing the write is the hazard/trap logic's job; this stage only reports faultW.
- fault_sticky <= fault_sticky | fault on each edge.
- Reset (rst = 0) asynchronously clears:
  - all memory words to 32'h0;
  - all W outputs to 0, fault_sticky to 0.
- Reset asserted mid-operation discards any store on that edge. No partial state survives.
- No stall or flush inputs: the stage advances every cycle. Bubbles arrive as regwriteM = memwriteM = resultsrcM = 0.

## Timing
- Latency: 1 cycle from M inputs to W outputs.
- Store visibility: a store at edge N is readable by a load presented in the cycle after edge N. That load's data appears on readdataW after edge N+1.
- Read-during-write is impossible within one instruction; only one access occurs per cycle.
- Every edge updates at most one memory word.
- Reset is async assert. W outputs read 0 with no clock edge while rst = 0.
- Deassertion is synchronous to clk by design assumption: the first capture happens on the first rising edge with rst = 1.
- With DEPTH = 64, byte address 0x100 (index 64) is the first out-of-range address. Address 0xFC (index 63) is the last valid one.

## Test plan
- Reset: hold rst = 0 with random M inputs and toggling clk. Required: all W outputs = 0, fault_sticky = 0. Then release and load from 0x0. Required: readdataW = 0 two cycles later.
- Store/load: store 0xDEADBEEF to 0x10, next cycle load 0x10 with RdM = 5, regwriteM = 1, resultsrcM = 1. Required after the load edge: readdataW = 0xDEADBEEF, RdW = 5, aluresultW = 0x10, faultW = 0.
- Back-to-back stores: store 0x1 to 0x20, then 0x2 to 0x20, then load 0x20. Required: readdataW = 0x2. A load of 0x24 returns 0.
- Misaligned: store 0xAAAA5555 to 0x12. Required: faultW = 1 next cycle and fault_sticky = 1. A subsequent load of 0x10 returns the prior contents. Load 0x13 gives readdataW = 0, faultW = 1.
- Out of range (DEPTH = 64):
  - store to 0x100 → faultW = 1 and no memory word changes; all 64 words are checked;
  - load 0xFC after a store of 0x7 to 0xFC → readdataW = 0x7;
  - ALU op with resultM = 0xFFFFFFF0 → faultW = 0, aluresultW = 0xFFFFFFF0.
- Mid-stream reset: store 0x55 to 0x8, pulse rst low for a half cycle, then load 0x8. Required: readdataW = 0, fault_sticky = 0, and all W outputs go to 0 asynchronously during the pulse.

Source files
------------

// File: rtl/memory_stage.sv
// ============================================================================
// Module   : memory_stage
// Purpose  : RISC-V MEM stage: internal word-addressed data memory, MEM/WB
//            pipeline register and misaligned/out-of-range access reporting.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module memory_stage #(
  parameter int DEPTH = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        regwriteM,
  input  logic        memwriteM,
  input  logic        resultsrcM,
  input  logic [31:0] resultM,
  input  logic [31:0] writedataM,
  input  logic [4:0]  RdM,
  input  logic [31:0] pc4M,
  output logic        regwriteW,
  output logic        resultsrcW,
  output logic [4:0]  RdW,
  output logic [31:0] pc4W,
  output logic [31:0] aluresultW,
  output logic [31:0] readdataW,
  output logic        faultW,
  output logic        fault_sticky
);

  localparam logic [31:0] C_DEPTH = 32'(DEPTH);

  logic [31:0]   r_mem [DEPTH];

  logic          w_aligned;
  logic          w_in_range;
  logic          w_fault;
  logic          w_we;
  logic [AW-1:0] w_idx;
  logic [31:0]   w_rdata;

  assign w_aligned  = (resultM[1:0] == 2'b00);
  assign w_in_range = ({2'b00, resultM[31:2]} < C_DEPTH);
  assign w_idx      = resultM[AW+1:2];

  // ALU-only instructions carry arbitrary results, so only memory ops may fault.
  assign w_fault    = (memwriteM | resultsrcM) & ~(w_aligned & w_in_range);
  assign w_we       = memwriteM & ~w_fault;
  assign w_rdata    = (w_aligned && w_in_range) ? r_mem[w_idx] : 32'h0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= 32'h0;
      end
    end else if (w_we) begin
      r_mem[w_idx] <= writedataM;
    end
  end

  // Write enable passes through on fault; trap logic downstream decides.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      regwriteW    <= 1'b0;
      resultsrcW   <= 1'b0;
      RdW          <= 5'd0;
      pc4W         <= 32'h0;
      aluresultW   <= 32'h0;
      readdataW    <= 32'h0;
      faultW       <= 1'b0;
      fault_sticky <= 1'b0;
    end else begin
      regwriteW    <= regwriteM;
      resultsrcW   <= resultsrcM;
      RdW          <= RdM;
      pc4W         <= pc4M;
      aluresultW   <= resultM;
      readdataW    <= w_rdata;
      faultW       <= w_fault;
      fault_sticky <= fault_sticky | w_fault;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_memory_stage.sv
// ============================================================================
// Module   : tb_memory_stage
// Purpose  : Scoreboard bench for memory_stage against a word-array model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_memory_stage;

  localparam int DEPTH = 64;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        regwriteM = 1'b0;
  logic        memwriteM = 1'b0;
  logic        resultsrcM = 1'b0;
  logic [31:0] resultM = '0;
  logic [31:0] writedataM = '0;
  logic [4:0]  RdM = '0;
  logic [31:0] pc4M = '0;
  logic        regwriteW;
  logic        resultsrcW;
  logic [4:0]  RdW;
  logic [31:0] pc4W;
  logic [31:0] aluresultW;
  logic [31:0] readdataW;
  logic        faultW;
  logic        fault_sticky;

  memory_stage #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .regwriteM(regwriteM), .memwriteM(memwriteM), .resultsrcM(resultsrcM),
    .resultM(resultM), .writedataM(writedataM), .RdM(RdM), .pc4M(pc4M),
    .regwriteW(regwriteW), .resultsrcW(resultsrcW), .RdW(RdW), .pc4W(pc4W),
    .aluresultW(aluresultW), .readdataW(readdataW), .faultW(faultW),
    .fault_sticky(fault_sticky)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rw;
    logic        rs;
    logic [4:0]  rd;
    logic [31:0] pc4;
    logic [31:0] alu;
    logic [31:0] rdata;
    logic        fault;
    logic        sticky;
  } exp_t;

  exp_t        q[$];
  logic [31:0] m_mem [DEPTH];
  logic        m_sticky;
  int          tests = 0;
  int          fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h, required %h at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) m_mem[i] = 32'h0;
    m_sticky = 1'b0;
  endtask

  // Drive one instruction now and record what the W stage must show after the next edge.
  task automatic drive(input logic rw, input logic mw, input logic rs,
                       input logic [31:0] addr, input logic [31:0] wd, input logic [4:0] rd);
    exp_t   e;
    longint widx;
    bit     ok;
    widx = longint'(addr) / 4;
    ok   = (addr % 4 == 0) && (widx < DEPTH);
    regwriteM = rw; memwriteM = mw; resultsrcM = rs;
    resultM = addr; writedataM = wd; RdM = rd; pc4M = $urandom;
    e.rw = rw; e.rs = rs; e.rd = rd; e.pc4 = pc4M; e.alu = addr;
    e.rdata  = ok ? m_mem[widx] : 32'h0;
    e.fault  = (mw || rs) && !ok;
    m_sticky = m_sticky | e.fault;
    e.sticky = m_sticky;
    q.push_back(e);
    if (mw && ok) m_mem[widx] = wd;
  endtask

  task automatic issue(input logic rw, input logic mw, input logic rs,
                       input logic [31:0] addr, input logic [31:0] wd, input logic [4:0] rd);
    @(negedge clk);
    drive(rw, mw, rs, addr, wd, rd);
  endtask

  task automatic store(input logic [31:0] addr, input logic [31:0] wd);
    issue(1'b0, 1'b1, 1'b0, addr, wd, 5'($urandom));
  endtask

  task automatic load(input logic [31:0] addr, input logic [4:0] rd);
    issue(1'b1, 1'b0, 1'b1, addr, $urandom, rd);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".W"}, {26'd0, regwriteW, resultsrcW, faultW, fault_sticky, 2'b00} | 32'(RdW), 32'h0);
    chk({tag, ".pc4W"}, pc4W, 32'h0);
    chk({tag, ".aluresultW"}, aluresultW, 32'h0);
    chk({tag, ".readdataW"}, readdataW, 32'h0);
  endtask

  // Monitor: the stage produces a bundle every edge; compare whenever one is expected.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("regwriteW", 32'(regwriteW), 32'(e.rw));
        chk("resultsrcW", 32'(resultsrcW), 32'(e.rs));
        chk("RdW", 32'(RdW), 32'(e.rd));
        chk("pc4W", pc4W, e.pc4);
        chk("aluresultW", aluresultW, e.alu);
        chk("readdataW", readdataW, e.rdata);
        chk("faultW", 32'(faultW), 32'(e.fault));
        chk("fault_sticky", 32'(fault_sticky), 32'(e.sticky));
      end
    end
  end

  initial begin
    int op;
    logic [31:0] a;
    model_reset();
    // Reset held with garbage inputs and a running clock.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      regwriteM = 1'b1; memwriteM = 1'b1; resultsrcM = 1'b1;
      resultM = 32'(4 * $urandom_range(0, 63)); writedataM = $urandom;
      RdM = 5'($urandom); pc4M = $urandom;
      @(posedge clk); #1;
      chk_all_zero("reset_hold");
    end
    @(negedge clk);
    rst = 1'b1;
    drive(1'b1, 1'b0, 1'b1, 32'h0, 32'h0, 5'd1);
    issue(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);

    store(32'h10, 32'hDEADBEEF);
    load(32'h10, 5'd5);
    store(32'h20, 32'h1);
    store(32'h20, 32'h2);
    load(32'h20, 5'd6);
    load(32'h24, 5'd7);
    store(32'h12, 32'hAAAA5555);
    load(32'h10, 5'd8);
    load(32'h13, 5'd9);
    store(32'h100, 32'h12345678);
    for (int i = 0; i < DEPTH; i++) load(32'(4 * i), 5'(i));
    store(32'hFC, 32'h7);
    load(32'hFC, 5'd10);
    issue(1'b1, 1'b0, 1'b0, 32'hFFFFFFF0, 32'h0, 5'd11);

    // Randomized mix of ALU ops, stores and loads, including faulting addresses.
    for (int n = 0; n < 400; n++) begin
      op = $urandom_range(0, 2);
      a  = {24'd0, 6'($urandom_range(0, 63)), 2'b00};
      case ($urandom_range(0, 7))
        0: a = a | 32'($urandom_range(1, 3));
        1: a = 32'(4 * $urandom_range(DEPTH, DEPTH + 8));
        2: a = $urandom;
        default: ;
      endcase
      if (op == 0)      issue(1'($urandom), 1'b0, 1'b0, a, $urandom, 5'($urandom));
      else if (op == 1) store(a, $urandom);
      else              load(a, 5'($urandom));
    end

    // Mid-stream reset pulse wipes the stored word and all W state.
    store(32'h8, 32'h55);
    @(negedge clk);
    rst = 1'b0;
    #2;
    chk_all_zero("async_reset");
    #2;
    rst = 1'b1;
    model_reset();
    drive(1'b1, 1'b0, 1'b1, 32'h8, 32'h0, 5'd3);
    issue(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);

    @(posedge clk); #2;
    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
